// File: rtl/alu_dispatch_if.sv
// Decode/regfile/ALU-side bundle of the dispatch sequencer.
// The slave modport is the sequencer's view of it. The master modport is the surrounding pipeline's view.
interface alu_dispatch_if;
    logic [31:0] instr_in;
    logic [31:0] pc_in;
    logic        instr_valid;
    logic        instr_ready;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] alu_instr;
    logic [31:0] alu_op1;
    logic [31:0] alu_op2;
    logic        alu_enable;
    logic        alu_instr_exec;
    logic [31:0] alu_result;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        done;
    logic        illegal;

    modport slave (
        input  instr_in, pc_in, instr_valid, rs1_data, rs2_data,
               alu_instr_exec, alu_result,
        output instr_ready, rs1_addr, rs2_addr, alu_instr, alu_op1, alu_op2,
               alu_enable, rf_we, rf_waddr, rf_wdata, done, illegal
    );

    modport master (
        output instr_in, pc_in, instr_valid, rs1_data, rs2_data,
               alu_instr_exec, alu_result,
        input  instr_ready, rs1_addr, rs2_addr, alu_instr, alu_op1, alu_op2,
               alu_enable, rf_we, rf_waddr, rf_wdata, done, illegal
    );
endinterface

// File: rtl/alu_dispatch.sv
// RV32I ALU issue/writeback sequencer. Accept to writeback takes 2 cycles, with one instruction retired per 3 cycles.
// The decoder holds its instruction while instr_ready is low, which is any state except IDLE and WB.
package opcodes;
    typedef logic [31:0] instruction_t;
    typedef logic [31:0] register_t;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    function automatic logic is_alu_op(input instruction_t instr);
        return (instr[6:0] == OP_R) || (instr[6:0] == OP_IMM) ||
               (instr[6:0] == OP_LUI) || (instr[6:0] == OP_AUIPC);
    endfunction

`ifndef SYNTHESIS
    function automatic string decode_instr(input instruction_t instr);
        return $sformatf("instr=%08h opc=%07b rd=x%0d f3=%0d rs1=x%0d rs2=x%0d",
                         instr, instr[6:0], instr[11:7], instr[14:12],
                         instr[19:15], instr[24:20]);
    endfunction
`endif
endpackage

module alu_dispatch
    import opcodes::*;
#(
    parameter bit trace = 1'b0
) (
    input  logic clk,
    input  logic rst,
    alu_dispatch_if.slave bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_WB    = 2'd3;

    logic [1:0]   state_q, state_d;
    instruction_t instr_q, instr_d;
    register_t    pc_q, pc_d;
    logic         rf_we_q, rf_we_d;
    logic [4:0]   rf_waddr_q, rf_waddr_d;
    logic [31:0]  rf_wdata_q, rf_wdata_d;
    logic         done_q, done_d;
    logic         illegal_q, illegal_d;

    logic        accept;
    logic [2:0]  funct3;
    logic [31:0] u_imm;
    logic [31:0] i_imm;

    assign bus.instr_ready = (state_q == S_IDLE) || (state_q == S_WB);
    assign accept          = bus.instr_valid && bus.instr_ready;

    assign funct3 = instr_q[14:12];
    assign u_imm  = {instr_q[31:12], 12'b0};
    assign i_imm  = {{20{instr_q[31]}}, instr_q[31:20]};

    assign bus.rs1_addr   = instr_q[19:15];
    assign bus.rs2_addr   = instr_q[24:20];
    assign bus.alu_instr  = instr_q;
    assign bus.alu_enable = (state_q == S_ISSUE);
    assign bus.rf_we      = rf_we_q;
    assign bus.rf_waddr   = rf_waddr_q;
    assign bus.rf_wdata   = rf_wdata_q;
    assign bus.done       = done_q;
    assign bus.illegal    = illegal_q;

    // Operands are only driven during the enable cycle so the ALU inputs stay quiet otherwise.
    always_comb begin
        bus.alu_op1 = '0;
        bus.alu_op2 = '0;
        if (state_q == S_ISSUE) begin
            case (instr_q[6:0])
                OP_R: begin
                    bus.alu_op1 = bus.rs1_data;
                    bus.alu_op2 = bus.rs2_data;
                end
                OP_IMM: begin
                    bus.alu_op1 = bus.rs1_data;
                    if (funct3 == 3'b001 || funct3 == 3'b101) begin
                        bus.alu_op2 = {27'b0, instr_q[24:20]};
                    end else begin
                        bus.alu_op2 = i_imm;
                    end
                end
                OP_LUI: begin
                    bus.alu_op1 = u_imm;
                end
                OP_AUIPC: begin
                    bus.alu_op1 = u_imm;
                    bus.alu_op2 = pc_q;
                end
                default: begin
                    bus.alu_op1 = '0;
                    bus.alu_op2 = '0;
                end
            endcase
        end
    end

    always_comb begin
        state_d    = state_q;
        instr_d    = instr_q;
        pc_d       = pc_q;
        rf_we_d    = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        done_d     = 1'b0;
        illegal_d  = 1'b0;
        case (state_q)
            S_IDLE, S_WB: begin
                if (accept) begin
                    instr_d = bus.instr_in;
                    pc_d    = bus.pc_in;
                    if (is_alu_op(bus.instr_in)) begin
                        state_d = S_ISSUE;
                    end else begin
                        // Non-ALU ops retire straight away as not executed.
                        state_d    = S_WB;
                        illegal_d  = 1'b1;
                        done_d     = 1'b1;
                        rf_waddr_d = '0;
                        rf_wdata_d = '0;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: begin
                state_d = S_WB;
                done_d  = 1'b1;
                if (bus.alu_instr_exec) begin
                    rf_waddr_d = instr_q[11:7];
                    rf_wdata_d = bus.alu_result;
                    rf_we_d    = |instr_q[11:7];
                end else begin
                    illegal_d  = 1'b1;
                    rf_waddr_d = '0;
                    rf_wdata_d = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            instr_q    <= '0;
            pc_q       <= '0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            done_q     <= 1'b0;
            illegal_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            instr_q    <= instr_d;
            pc_q       <= pc_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            done_q     <= done_d;
            illegal_q  <= illegal_d;
        end
    end

`ifndef SYNTHESIS
    if (trace) begin : g_trace
        always @(posedge clk) begin
            if (rst && accept) begin
                $display("%t %s", $time, decode_instr(bus.instr_in));
            end
        end
    end
`endif
endmodule

// File: tb/tb_alu_dispatch.sv
// Bench for alu_dispatch: a registered ALU and a static register file surround the DUT.
// Results are predicted from RV32I instruction semantics.
module tb_alu_dispatch;
    logic clk;
    logic rst_n;
    logic alu_fail;
    logic [31:0] rf [32];
    int checks;
    int errors;

    alu_dispatch_if bus ();

    alu_dispatch #(.trace(1'b0)) dut (
        .clk (clk),
        .rst (rst_n),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus.rs1_data = (bus.rs1_addr == 5'd0) ? 32'd0 : rf[bus.rs1_addr];
    assign bus.rs2_data = (bus.rs2_addr == 5'd0) ? 32'd0 : rf[bus.rs2_addr];

    function automatic logic [31:0] alu_core(input logic [2:0] f3, input logic sub,
                                             input logic sra, input logic [31:0] a,
                                             input logic [31:0] b);
        case (f3)
            3'd0: return sub ? a - b : a + b;
            3'd1: return a << b[4:0];
            3'd2: return {31'b0, $signed(a) < $signed(b)};
            3'd3: return {31'b0, a < b};
            3'd4: return a ^ b;
            3'd5: return sra ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
            3'd6: return a | b;
            default: return a & b;
        endcase
    endfunction

    // ALU stand-in: it sees only the DUT's operands and is registered, like the real unit.
    function automatic logic [31:0] alu_calc(input logic [31:0] ins, input logic [31:0] a,
                                             input logic [31:0] b);
        if (ins[6:0] == 7'b0110011) return alu_core(ins[14:12], ins[30], ins[30], a, b);
        if (ins[6:0] == 7'b0010011) return alu_core(ins[14:12], 1'b0, ins[30], a, b);
        return a + b;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.alu_instr_exec <= 1'b0;
            bus.alu_result     <= 32'd0;
        end else if (bus.alu_enable) begin
            bus.alu_instr_exec <= !alu_fail;
            bus.alu_result     <= alu_calc(bus.alu_instr, bus.alu_op1, bus.alu_op2);
        end else begin
            bus.alu_instr_exec <= 1'b0;
        end
    end

    // Reference: the architectural rd value of an RV32I ALU instruction.
    function automatic logic [31:0] ref_result(input logic [31:0] ins, input logic [31:0] pc);
        logic [31:0] a;
        logic [31:0] b;
        a = (ins[19:15] == 5'd0) ? 32'd0 : rf[ins[19:15]];
        b = (ins[24:20] == 5'd0) ? 32'd0 : rf[ins[24:20]];
        case (ins[6:0])
            7'b0110011: return alu_core(ins[14:12], ins[30], ins[30], a, b);
            7'b0010011: begin
                if (ins[14:12] == 3'd1 || ins[14:12] == 3'd5) b = 32'(ins[24:20]);
                else b = 32'($signed(ins[31:20]));
                return alu_core(ins[14:12], 1'b0, ins[30], a, b);
            end
            7'b0110111: return {ins[31:12], 12'b0};
            default:    return {ins[31:12], 12'b0} + pc;
        endcase
    endfunction

    logic        o_en   [3];
    logic        o_we   [3];
    logic        o_done [3];
    logic        o_ill  [3];
    logic [31:0] o_op1, o_op2, o_wdata;
    logic [4:0]  o_rs1a, o_waddr;

    // Waits for ready, presents one instruction and records three cycles of outputs after the accept.
    task automatic issue_one(input logic [31:0] ins, input logic [31:0] pc);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.instr_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 20) begin
            errors++;
            $display("FAIL ready_timeout: instr_ready stayed %0b, required 1", bus.instr_ready);
        end
        bus.instr_in    = ins;
        bus.pc_in       = pc;
        bus.instr_valid = 1'b1;
        @(posedge clk);
        #1 bus.instr_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            o_en[c]   = bus.alu_enable;
            o_we[c]   = bus.rf_we;
            o_done[c] = bus.done;
            o_ill[c]  = bus.illegal;
            if (c == 0) begin
                o_op1  = bus.alu_op1;
                o_op2  = bus.alu_op2;
                o_rs1a = bus.rs1_addr;
            end
            if (c == 2) begin
                o_waddr = bus.rf_waddr;
                o_wdata = bus.rf_wdata;
            end
        end
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({bus.rf_we, bus.done, bus.illegal, bus.alu_enable} !== 4'b0 ||
            bus.rf_waddr !== 5'd0 || bus.rf_wdata !== 32'd0 || bus.alu_instr !== 32'd0) begin
            errors++;
            $display("FAIL reset_outputs: we/done/ill/en=%b%b%b%b waddr=%0d wdata=%h instr=%h, required all 0",
                     bus.rf_we, bus.done, bus.illegal, bus.alu_enable, bus.rf_waddr, bus.rf_wdata, bus.alu_instr);
        end
        checks++;
        if (bus.alu_op1 !== 32'd0 || bus.alu_op2 !== 32'd0 || bus.instr_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ops_ready: op1=%h op2=%h ready=%b, required 0 0 1",
                     bus.alu_op1, bus.alu_op2, bus.instr_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.instr_ready !== 1'b1 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idle: ready=%b done=%b, required 1 0", bus.instr_ready, bus.done);
        end
    endtask

    task automatic test_operands();
        logic [31:0] ins [3] = '{32'hFFF00293, 32'h123450B7, 32'h00001117};
        logic [31:0] pcs [3] = '{32'h0, 32'h0, 32'h100};
        logic [31:0] e1  [3] = '{32'h0, 32'h12345000, 32'h1000};
        logic [31:0] e2  [3] = '{32'hFFFFFFFF, 32'h0, 32'h100};
        logic [31:0] ew  [3] = '{32'hFFFFFFFF, 32'h12345000, 32'h1100};
        logic [4:0]  ea  [3] = '{5'd5, 5'd1, 5'd2};
        for (int i = 0; i < 3; i++) begin
            issue_one(ins[i], pcs[i]);
            checks++;
            if (o_en[0] !== 1'b1 || o_op1 !== e1[i] || o_op2 !== e2[i]) begin
                errors++;
                $display("FAIL issue_ops[%0d]: en=%b op1=%h op2=%h, required 1 %h %h",
                         i, o_en[0], o_op1, o_op2, e1[i], e2[i]);
            end
            checks++;
            if (o_we[2] !== 1'b1 || o_done[2] !== 1'b1 || o_waddr !== ea[i] || o_wdata !== ew[i] ||
                o_we[0] !== 1'b0 || o_we[1] !== 1'b0 || o_ill[2] !== 1'b0) begin
                errors++;
                $display("FAIL writeback[%0d]: we=%b done=%b waddr=%0d wdata=%h ill=%b, required 1 1 %0d %h 0",
                         i, o_we[2], o_done[2], o_waddr, o_wdata, o_ill[2], ea[i], ew[i]);
            end
        end
    endtask

    task automatic test_shift_x0();
        rf[4] = 32'h80000000;
        rf[1] = 32'h00000011;
        rf[2] = 32'h00000022;
        issue_one(32'h40425193, 32'h0);
        checks++;
        if (o_op1 !== 32'h80000000 || o_op2 !== 32'd4 || o_rs1a !== 5'd4) begin
            errors++;
            $display("FAIL srai_ops: op1=%h op2=%h rs1_addr=%0d, required 80000000 4 4", o_op1, o_op2, o_rs1a);
        end
        checks++;
        if (o_wdata !== 32'hF8000000 || o_waddr !== 5'd3 || o_we[2] !== 1'b1) begin
            errors++;
            $display("FAIL srai_wb: wdata=%h waddr=%0d we=%b, required F8000000 3 1", o_wdata, o_waddr, o_we[2]);
        end
        issue_one(32'h00208033, 32'h0);
        checks++;
        if (o_done[2] !== 1'b1 || o_we[2] !== 1'b0 || o_ill[2] !== 1'b0 ||
            o_waddr !== 5'd0 || o_wdata !== 32'h33) begin
            errors++;
            $display("FAIL add_x0: done=%b we=%b ill=%b waddr=%0d wdata=%h, required 1 0 0 0 00000033",
                     o_done[2], o_we[2], o_ill[2], o_waddr, o_wdata);
        end
    endtask

    task automatic test_illegal();
        issue_one(32'h00002003, 32'h0);
        checks++;
        if (o_en[0] !== 1'b0 || o_en[1] !== 1'b0 || o_ill[0] !== 1'b1 || o_done[0] !== 1'b1 ||
            o_we[0] !== 1'b0 || o_done[1] !== 1'b0 || o_ill[1] !== 1'b0) begin
            errors++;
            $display("FAIL lw_illegal: en=%b%b ill=%b%b done=%b%b we=%b, required 00 10 10 0",
                     o_en[0], o_en[1], o_ill[0], o_ill[1], o_done[0], o_done[1], o_we[0]);
        end
        alu_fail = 1'b1;
        issue_one(32'h00700393, 32'h0);
        alu_fail = 1'b0;
        checks++;
        if (o_en[0] !== 1'b1 || o_ill[2] !== 1'b1 || o_done[2] !== 1'b1 || o_we[2] !== 1'b0) begin
            errors++;
            $display("FAIL exec0_illegal: en=%b ill=%b done=%b we=%b, required 1 1 1 0",
                     o_en[0], o_ill[2], o_done[2], o_we[2]);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] ins [3];
        logic [31:0] exp_d [3];
        int acc_c [3];
        int we_c [3];
        logic [4:0]  wa [3];
        logic [31:0] wd [3];
        int idx, nw;
        logic r;
        for (int i = 0; i < 3; i++) begin
            rf[i + 1] = $urandom;
            ins[i] = {12'($urandom_range(0, 4095)), 5'(i + 1), 3'b000, 5'(i + 11), 7'b0010011};
            exp_d[i] = ref_result(ins[i], 32'h0);
        end
        idx = 0;
        nw = 0;
        @(negedge clk);
        bus.instr_in    = ins[0];
        bus.instr_valid = 1'b1;
        for (int c = 0; c < 12; c++) begin
            r = bus.instr_ready;
            @(posedge clk);
            if (r && bus.instr_valid) begin
                acc_c[idx] = c;
                idx++;
                #1;
                if (idx < 3) bus.instr_in = ins[idx];
                else bus.instr_valid = 1'b0;
            end
            @(negedge clk);
            if (bus.rf_we === 1'b1 && nw < 3) begin
                we_c[nw] = c;
                wa[nw] = bus.rf_waddr;
                wd[nw] = bus.rf_wdata;
                nw++;
            end
        end
        bus.instr_valid = 1'b0;
        checks++;
        if (idx != 3 || nw != 3) begin
            errors++;
            $display("FAIL b2b_counts: accepts=%0d writes=%0d, required 3 3", idx, nw);
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (acc_c[i] != 3 * i || we_c[i] != 3 * i + 2 || wa[i] !== 5'(i + 11) || wd[i] !== exp_d[i]) begin
                    errors++;
                    $display("FAIL b2b[%0d]: accept E%0d we E%0d waddr=%0d wdata=%h, required E%0d E%0d %0d %h",
                             i, acc_c[i], we_c[i], wa[i], wd[i], 3 * i, 3 * i + 2, i + 11, exp_d[i]);
                end
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] ins, pc, r20, expv;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  rd, rs1, rs2;
        int cls;
        logic [6:0] bad_ops [3] = '{7'b0000011, 7'b0100011, 7'b1100011};
        for (int i = 1; i < 32; i++) rf[i] = $urandom;
        for (int n = 0; n < 40; n++) begin
            cls = $urandom_range(0, 4);
            rd  = 5'($urandom_range(0, 31));
            rs1 = 5'($urandom_range(0, 31));
            rs2 = 5'($urandom_range(0, 31));
            f3  = 3'($urandom_range(0, 7));
            r20 = $urandom;
            pc  = $urandom & 32'hFFFFFFFC;
            f7  = 7'h00;
            case (cls)
                0: begin
                    if ((f3 == 3'd0 || f3 == 3'd5) && $urandom_range(0, 1) == 1) f7 = 7'h20;
                    ins = {f7, rs2, rs1, f3, rd, 7'b0110011};
                end
                1: begin
                    if (f3 == 3'd5 && $urandom_range(0, 1) == 1) f7 = 7'h20;
                    if (f3 == 3'd1 || f3 == 3'd5) ins = {f7, rs2, rs1, f3, rd, 7'b0010011};
                    else ins = {r20[11:0], rs1, f3, rd, 7'b0010011};
                end
                2: ins = {r20[19:0], rd, 7'b0110111};
                3: ins = {r20[19:0], rd, 7'b0010111};
                default: ins = {r20[24:0], bad_ops[$urandom_range(0, 2)]};
            endcase
            issue_one(ins, pc);
            checks++;
            if (cls == 4) begin
                if (o_ill[0] !== 1'b1 || o_done[0] !== 1'b1 || o_en[0] !== 1'b0 || o_we[0] !== 1'b0) begin
                    errors++;
                    $display("FAIL rand_illegal[%0d] %h: ill=%b done=%b en=%b we=%b, required 1 1 0 0",
                             n, ins, o_ill[0], o_done[0], o_en[0], o_we[0]);
                end
            end else begin
                expv = ref_result(ins, pc);
                if (o_wdata !== expv || o_waddr !== ins[11:7] || o_we[2] !== (ins[11:7] != 5'd0) ||
                    o_done[2] !== 1'b1 || o_ill[2] !== 1'b0 || o_en[0] !== 1'b1) begin
                    errors++;
                    $display("FAIL rand_alu[%0d] %h: wdata=%h waddr=%0d we=%b done=%b ill=%b, required %h %0d %b 1 0",
                             n, ins, o_wdata, o_waddr, o_we[2], o_done[2], o_ill[2],
                             expv, ins[11:7], ins[11:7] != 5'd0);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic saw_we, saw_done;
        saw_we = 1'b0;
        saw_done = 1'b0;
        @(negedge clk);
        bus.instr_in    = 32'h00500393;
        bus.instr_valid = 1'b1;
        @(posedge clk);
        #1 bus.instr_valid = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.rf_we !== 1'b0 || bus.done !== 1'b0 || bus.alu_enable !== 1'b0 ||
            bus.alu_instr !== 32'd0 || bus.instr_ready !== 1'b1) begin
            errors++;
            $display("FAIL async_reset: we=%b done=%b en=%b instr=%h ready=%b, required 0 0 0 0 1",
                     bus.rf_we, bus.done, bus.alu_enable, bus.alu_instr, bus.instr_ready);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.instr_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_release: ready=%b, required 1", bus.instr_ready);
        end
        for (int c = 0; c < 5; c++) begin
            if (bus.rf_we === 1'b1) saw_we = 1'b1;
            if (bus.done === 1'b1) saw_done = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (saw_we !== 1'b0 || saw_done !== 1'b0) begin
            errors++;
            $display("FAIL abandoned_write: saw we=%b done=%b, required 0 0", saw_we, saw_done);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        alu_fail = 1'b0;
        bus.instr_in = 32'd0;
        bus.pc_in = 32'd0;
        bus.instr_valid = 1'b0;
        for (int i = 0; i < 32; i++) rf[i] = 32'd0;
        test_reset();
        test_operands();
        test_shift_x0();
        test_illegal();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/alu_dispatch.md
Name: alu_dispatch

Overview:
Issue/writeback sequencer around the single-cycle-latency ALU. Accepts one decoded RV32I instruction at a time from the decoder over a valid/ready handshake and reads rs1/rs2 from the register file. It builds op1/op2 (register, sign-extended immediate, shamt, U-immediate, PC), pulses the ALU enable, then writes the ALU result back to rd. Sits between decode and the register-file write port; instructions and types come from package opcodes (instruction_t, register_t, is_alu_op).

Parameters:
trace, 0, when 1 and not SYNTHESIS, $display time plus decode_instr() at each accept.

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  reset, asynchronous, active-low (0 = reset)
instr_in  in  32 (instruction_t)  instruction from decoder
pc_in  in  32 (register_t)  PC of instr_in
instr_valid  in  1  instr_in/pc_in valid
instr_ready  out  1  dispatch can accept
rs1_addr  out  5  regfile read addr 1 = instr[19:15] of held instr
rs2_addr  out  5  regfile read addr 2 = instr[24:20] of held instr
rs1_data  in  32  regfile read data 1, combinational from rs1_addr
rs2_data  in  32  regfile read data 2, combinational from rs2_addr
alu_instr  out  32  held instruction to ALU
alu_op1  out  32  ALU operand 1
alu_op2  out  32  ALU operand 2
alu_enable  out  1  ALU enable, one-cycle pulse
alu_instr_exec  in  1  ALU executed flag (registered in ALU)
alu_result  in  32  ALU result (registered in ALU)
rf_we  out  1  regfile write enable
rf_waddr  out  5  regfile write address
rf_wdata  out  32  regfile write data
done  out  1  one-cycle pulse per retired instruction
illegal  out  1  one-cycle pulse: instruction not executed

Behaviour:
- States: IDLE, ISSUE, WAIT, WB. Async reset -> IDLE; held instr, held pc, rf_we, rf_waddr, rf_wdata, done, and illegal all 0. Reset mid-operation abandons the instruction; no write is issued after reset release.
- instr_ready = (state==IDLE) || (state==WB), combinational. Accept = instr_valid && instr_ready at a rising edge: capture instr_in and pc_in.
  - Accept with is_alu_op(instr_in) -> ISSUE.
  - Accept with non-ALU op -> WB with illegal=1, done=1, rf_we=0. No alu_enable.
- ISSUE (1 cycle): alu_enable=1; alu_op1/alu_op2 combinational from held instr and rs data:
  - R-type (opcode 0110011): op1=rs1_data, op2=rs2_data.
  - I-type ALU (0010011), non-shift: op1=rs1_data, op2=sign-extend instr[31:20].
  - SLLI/SRLI/SRAI (funct3 001/101): op2={27'b0, instr[24:20]}.
  - LUI (0110111): op1={instr[31:12],12'b0}, op2=0.
  - AUIPC (0010111): op1={instr[31:12],12'b0}, op2=held pc.
  - Next state: WAIT.
- Outside ISSUE: alu_enable=0, alu_op1/alu_op2 = 0. alu_instr = held instr in all states.
- WAIT (1 cycle): sample alu_instr_exec/alu_result. Next edge -> WB.
  - If exec=1: register rf_waddr=instr[11:7], rf_wdata=alu_result, rf_we=(rd!=0), done=1.
  - If exec=0: rf_we=0, illegal=1, done=1.
- WB (1 cycle): rf_we/done/illegal are high only here, then cleared.
  - Accept in WB -> ISSUE (or WB if non-ALU).
  - No accept -> IDLE.
- Latency: accept edge E0 -> alu_enable high in E0..E1 -> rf_we high in E2..E3.
- Peak throughput: one instruction per 3 cycles (back-to-back via WB overlap).
- rd=x0: done=1, rf_we=0, rf_waddr=0, rf_wdata=alu_result, no error.
- instr_valid while not ready: ignored; the decoder holds its inputs.

Test Plan:
- ADDI x5,x0,-1 (0xFFF00293), rs1_data=0 -> ISSUE op1=0, op2=0xFFFFFFFF; 2 cycles later rf_we=1, waddr=5, wdata=0xFFFFFFFF, done=1.
- LUI x1,0x12345 (0x123450B7) -> op1=0x12345000, op2=0, wdata=0x12345000. AUIPC x2,1 (0x00001117), pc=0x100 -> op1=0x1000, op2=0x100, wdata=0x1100.
- SRAI x3,x4,4 (0x40425193), rs1_data=0x80000000 -> op2=4, wdata=0xF8000000. ADD x0,x1,x2 -> done=1, rf_we stays 0.
- LW (0x00002003) accepted -> alu_enable never 1, next cycle illegal=1, done=1, rf_we=0. ALU returning exec=0 for an ALU op -> illegal=1, no write.
- instr_valid held high with 3 ADDIs -> accepts at E0, E3, E6; rf_we at E2..E3, E5..E6, E8..E9 with correct rd/data in order.
- rst=0 asynchronously during WAIT -> outputs 0 immediately, no rf_we after release; instr_ready=1 the first cycle after release.
